// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : timer_counter
//  Purpose  : Programmable 32-bit down-counting timer with a bus-register
//             interface (CTRL / PRESET / COUNT) and a maskable interrupt.
//             One-shot (MODE 00, 10, 11) and auto-reload (MODE 01) operation.
//  Ports    :
//    clk    in   1   system clock, rising edge
//    reset  in   1   asynchronous active-high reset
//    addr   in   30  word address [31:2]; only addr[3:2] decoded
//    we     in   1   write strobe (already range-decoded by the bridge)
//    din    in   32  merged write word
//    dout   out  32  combinational read of the selected register
//    irq    out  1   CTRL.IM & irq_flag
//  Optional : define TC_PRESCALE_EN to add the PSC prescaler register at
//             word offset 3.
//  Revision : 1.0  initial release
// ============================================================================
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] OFS_PSC    = 2'd3;

  state_t      state;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        tick;
  logic [1:0]  ofs;

  assign ofs = addr[3:2];

  // Only the low two word-address bits select a register.
  logic unused_ok;
  assign unused_ok = &{1'b0, addr[31:4]};

`ifdef TC_PRESCALE_EN
  logic [31:0] psc;
  logic [31:0] div;
  // Count/terminal step only once every PSC+1 CNT cycles.
  assign tick = (div == psc);
`else
  assign tick = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    dout = 32'h0;
    case (ofs)
      OFS_CTRL:   dout = {28'h0, ctrl_im, ctrl_mode, ctrl_en};
      OFS_PRESET: dout = preset;
      OFS_COUNT:  dout = count;
`ifdef TC_PRESCALE_EN
      OFS_PSC:    dout = psc;
`else
      OFS_PSC:    dout = 32'h0;
`endif
      default:    dout = 32'h0;
    endcase
  end

  assign irq = ctrl_im & irq_flag;

  // --------------------------------------------------------------------------
  // FSM and register file. The software write block sits after the FSM so a
  // bus write landing on the same edge as an FSM update to CTRL or irq_flag
  // takes precedence.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= PRESET_RST;
      count     <= 32'h0;
      irq_flag  <= 1'b0;
`ifdef TC_PRESCALE_EN
      psc       <= 32'h0;
      div       <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
`ifdef TC_PRESCALE_EN
          div   <= 32'h0;
`endif
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (tick) begin
`ifdef TC_PRESCALE_EN
            div <= 32'h0;
`endif
            // A preset of 0 or 1 terminates on the first CNT step.
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= 32'h0;
              irq_flag <= 1'b1;
              state    <= INT;
            end
          end else begin
`ifdef TC_PRESCALE_EN
            div <= div + 32'd1;
`endif
          end
        end
        INT: begin
          // Only MODE 01 auto-reloads; the other encodings act as one-shot.
          if (ctrl_mode == 2'b01) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl_en  <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (we) begin
        case (ofs)
          OFS_CTRL: begin
            ctrl_en   <= din[0];
            ctrl_mode <= din[2:1];
            ctrl_im   <= din[3];
            irq_flag  <= 1'b0;
          end
          OFS_PRESET: begin
            preset    <= din;
            irq_flag  <= 1'b0;
          end
          OFS_PSC: begin
`ifdef TC_PRESCALE_EN
            psc <= din;
            div <= 32'h0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_counter
//  Purpose  : Directed testbench for timer_counter. Stimulus pushes expected
//             register/irq values into a queue; a monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_counter;

  localparam logic [31:0] PRESET_RST = 32'h0000_00A5;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  timer_counter #(.PRESET_RST(PRESET_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ofs;
    logic [31:0] exp_dout;
    logic        exp_irq;
    string       name;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: each sample strobe presents DUT outputs for the oldest entry.
  always @(sample_ev) begin
    if (q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL monitor: sample with empty queue, got dout=%h irq=%b", dout, irq);
    end else begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (dout !== e.exp_dout || irq !== e.exp_irq) begin
        n_miss++;
        $display("FAIL %s: ofs=%0d got dout=%h irq=%b, expected dout=%h irq=%b",
                 e.name, e.ofs, dout, irq, e.exp_dout, e.exp_irq);
      end
    end
  end

  // Bus write occupying exactly one rising edge; returns 1 unit after it.
  task automatic do_write(input logic [1:0] ofs, input logic [31:0] d);
    addr = {28'h0, ofs};
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [1:0] ofs, input logic [31:0] ed,
                       input logic ei, input string name);
    exp_t e;
    addr = {28'h0, ofs};
    e.ofs = ofs; e.exp_dout = ed; e.exp_irq = ei; e.name = name;
    q.push_back(e);
    #1;
    -> sample_ev;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = '0; we = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    check(2'd0, 32'h0, 1'b0, "rst_ctrl");
    check(2'd1, PRESET_RST, 1'b0, "rst_preset");
    check(2'd2, 32'h0, 1'b0, "rst_count");
    idle(1);
    check(2'd3, 32'h0, 1'b0, "rst_ofs3");

    // Mode 0: PRESET=3, CTRL=0x9
    do_write(2'd1, 32'd3);
    do_write(2'd0, 32'h9);                       // E0
    check(2'd0, 32'h9, 1'b0, "m0_ctrl_e0");
    idle(2); check(2'd2, 32'd3, 1'b0, "m0_cnt_e2");
    idle(1); check(2'd2, 32'd2, 1'b0, "m0_cnt_e3");
    idle(1); check(2'd2, 32'd1, 1'b0, "m0_cnt_e4");
    idle(1); check(2'd2, 32'd0, 1'b1, "m0_cnt_e5");
    idle(1); check(2'd0, 32'h8, 1'b1, "m0_ctrl_e6");
    idle(3); check(2'd2, 32'd0, 1'b1, "m0_irq_hold");
    do_write(2'd0, 32'h8);
    check(2'd0, 32'h8, 1'b0, "m0_irq_clear");

    // Mode 1: PRESET=2, CTRL=0xB
    do_write(2'd1, 32'd2);
    do_write(2'd0, 32'hB);                       // E0
    idle(3); check(2'd2, 32'd1, 1'b0, "m1_e3");
    idle(1); check(2'd2, 32'd0, 1'b1, "m1_irq_e4");
    idle(1); check(2'd2, 32'd0, 1'b0, "m1_pulse_e5");
    idle(2); check(2'd2, 32'd2, 1'b0, "m1_reload_e7");
    idle(1); check(2'd2, 32'd1, 1'b0, "m1_e8");
    idle(1); check(2'd2, 32'd0, 1'b1, "m1_irq_e9");
    idle(1); check(2'd2, 32'd0, 1'b0, "m1_pulse_e10");
    idle(2); check(2'd2, 32'd2, 1'b0, "m1_reload_e12");
    do_write(2'd0, 32'h0);                       // E13, count 2->1
    idle(1); check(2'd2, 32'd1, 1'b0, "m1_stop");

    // Disable mid-count: PRESET=10, EN at E0, PRESET rewrite at E3, CTRL=0 at E5
    do_write(2'd1, 32'd10);
    do_write(2'd0, 32'h1);                       // E0
    idle(2); check(2'd2, 32'd10, 1'b0, "dis_e2");
    do_write(2'd1, 32'd50);                      // E3
    check(2'd2, 32'd9, 1'b0, "dis_preset_nofx");
    idle(1); check(2'd2, 32'd8, 1'b0, "dis_e4");
    do_write(2'd0, 32'h0);                       // E5
    check(2'd2, 32'd7, 1'b0, "dis_e5");
    idle(3); check(2'd2, 32'd7, 1'b0, "dis_frozen");
    do_write(2'd2, 32'h55);
    check(2'd2, 32'd7, 1'b0, "dis_wr_count");
    do_write(2'd3, 32'h77);
    check(2'd2, 32'd7, 1'b0, "dis_wr_ofs3");
    check(2'd3, 32'h0, 1'b0, "dis_ofs3_rd");
    check(2'd1, 32'd50, 1'b0, "dis_preset_rd");

    // PRESET=0, IM=0
    do_write(2'd1, 32'd0);
    do_write(2'd0, 32'h1);                       // E0
    idle(2); check(2'd2, 32'd0, 1'b0, "p0_e2");
    idle(1); check(2'd2, 32'd0, 1'b0, "p0_int_noirq");
    idle(1); check(2'd0, 32'h0, 1'b0, "p0_en_clr");

    // CTRL write on the edge INT clears EN
    do_write(2'd0, 32'h1);                       // E0
    idle(3);                                     // after E3: INT
    do_write(2'd0, 32'h1);                       // E4
    check(2'd0, 32'h1, 1'b0, "coll_sw_wins");
    idle(4); check(2'd0, 32'h0, 1'b0, "coll_rerun_done");

    // PRESET write on the edge irq_flag sets
    do_write(2'd1, 32'd1);
    do_write(2'd0, 32'h9);                       // E0
    idle(2); check(2'd2, 32'd1, 1'b0, "fcoll_e2");
    do_write(2'd1, 32'd1);                       // E3
    check(2'd2, 32'd0, 1'b0, "fcoll_flag_clr");
    idle(1); check(2'd0, 32'h8, 1'b0, "fcoll_e4");

    // MODE 10 reads back, upper bits dropped, one-shot behaviour
    do_write(2'd0, 32'hFFFF_FFF5);               // E0
    check(2'd0, 32'h5, 1'b0, "m2_readback");
    idle(4); check(2'd0, 32'h4, 1'b0, "m2_oneshot");

    // Reset mid-count
    do_write(2'd1, 32'd5);
    do_write(2'd0, 32'h9);                       // E0
    idle(3); check(2'd2, 32'd4, 1'b0, "rmc_e3");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check(2'd2, 32'h0, 1'b0, "rmc_count");
    check(2'd0, 32'h0, 1'b0, "rmc_ctrl");
    check(2'd1, PRESET_RST, 1'b0, "rmc_preset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(8); check(2'd2, 32'h0, 1'b0, "rmc_idle");

    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected entries never sampled", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
